// File: rtl/grid_link_pkg.sv
// Shared types and helpers for the grid serial link controller.
// Optional feature macro: GRID_LINK_STEP_EN adds the STEP state.
package grid_link_pkg;

   // Controller states. STEP exists only when single-step support is built in.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      READ = 2'd2
`ifdef GRID_LINK_STEP_EN
      ,
      STEP = 2'd3
`endif
   } link_state_t;

   // Bit counter width: must hold values up to DATA_SIZE+1 without wrapping,
   // because READ runs the counter one past DATA_SIZE on its final edge.
   function automatic int cnt_width(input int data_size);
      return $clog2(data_size + 2);
   endfunction

endpackage : grid_link_pkg

// File: rtl/grid_serial_link_shift_reg.sv
// link_shift_reg: generic shifter used for both the transmit and the capture
// path of the grid serial link. Parallel load has priority over shifting;
// shifting moves bits toward the MSB and inserts serial_in at the LSB.
module link_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] shifted;

   // A one-bit shifter simply takes the serial input; wider ones shift left.
   if (WIDTH == 1) begin : g_one
      assign shifted = serial_in;
   end else begin : g_wide
      assign shifted = {q[WIDTH-2:0], serial_in};
   end

   // Shift register storage: parallel load, else shift, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values, matching hardware regardless of block ordering.
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift) begin
         q <= shifted;
      end
   end

endmodule : link_shift_reg

// File: rtl/grid_serial_link.sv
// grid_serial_link: host-side controller for the system memory serial port.
// Loads a parallel grid word into the memory MSB first (SERIAL_IN/LOAD_MODE)
// and captures a word back from it (OUTPUT_MODE/SERIAL_OUT). All outputs are
// registered and at most one memory mode pin is ever high.
// Optional feature macro: GRID_LINK_STEP_EN adds STEP_REQ/RUN_MODE and the
// STEP state; without it the memory RUN_MODE pin is tied low outside this block.
module grid_serial_link
   import grid_link_pkg::*;
#(
   parameter int DATA_SIZE = 5
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 WR_VALID,
   input  logic [DATA_SIZE-1:0] WR_DATA,
   output logic                 WR_READY,
   input  logic                 RD_REQ,
   output logic                 RD_VALID,
   output logic [DATA_SIZE-1:0] RD_DATA,
   output logic                 SERIAL_IN,
   output logic                 LOAD_MODE,
   output logic                 OUTPUT_MODE,
   input  logic                 SERIAL_OUT
`ifdef GRID_LINK_STEP_EN
   ,
   input  logic                 STEP_REQ,
   output logic                 RUN_MODE
`endif
);

   localparam int CNT_W = cnt_width(DATA_SIZE);
   localparam int CAP_W = DATA_SIZE - 1;

   // Counter landmarks: the last payload edge of LOAD / last shift-out edge of
   // READ, and the READ edge that takes the final bit and publishes the word.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_SIZE);

   link_state_t            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic                   wr_ready_d;
   logic                   load_mode_d;
   logic                   output_mode_d;
   logic                   rd_valid_d;
   logic [DATA_SIZE-1:0]   rd_data_d;
`ifdef GRID_LINK_STEP_EN
   logic                   run_mode_d;
`endif

   logic                   tx_load;
   logic                   tx_shift;
   logic [DATA_SIZE-1:0]   tx_q;

   logic                   cap_shift;
   logic [CAP_W-1:0]       cap_q;

   // The transmit shifter latches the accepted word; its MSB is SERIAL_IN, so
   // the line always carries the current bit and drains to 0 after the last one.
   link_shift_reg #(
      .WIDTH     (DATA_SIZE)
   ) u_tx_shift (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .load      (tx_load),
      .load_data (WR_DATA),
      .shift     (tx_shift),
      .serial_in (1'b0),
      .q         (tx_q)
   );

   assign SERIAL_IN = tx_q[DATA_SIZE-1];

   // The capture shifter only needs DATA_SIZE-1 bits: the final bit goes
   // straight from SERIAL_OUT into RD_DATA on the completing edge.
   link_shift_reg #(
      .WIDTH     (CAP_W)
   ) u_cap_shift (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .load      (1'b0),
      .load_data ('0),
      .shift     (cap_shift),
      .serial_in (SERIAL_OUT),
      .q         (cap_q)
   );

   // Next-state, counter and registered-output logic for the link FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves a
      // value unassigned, which would otherwise infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      load_mode_d   = LOAD_MODE;
      output_mode_d = OUTPUT_MODE;
      rd_valid_d    = 1'b0;
      rd_data_d     = RD_DATA;
      tx_load       = 1'b0;
      tx_shift      = 1'b0;
      cap_shift     = 1'b0;
`ifdef GRID_LINK_STEP_EN
      run_mode_d    = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            // Priority: write, then step, then read.
            if (WR_VALID && WR_READY) begin
               state_d     = LOAD;
               tx_load     = 1'b1;
               load_mode_d = 1'b1;
               cnt_d       = '0;
`ifdef GRID_LINK_STEP_EN
            end else if (STEP_REQ) begin
               state_d     = STEP;
               run_mode_d  = 1'b1;
`endif
            end else if (RD_REQ) begin
               state_d       = READ;
               output_mode_d = 1'b1;
               cnt_d         = '0;
            end
         end

         LOAD: begin
            // Present the next lower bit each edge; the memory takes bit
            // DATA_SIZE-1-k on the (k+1)-th edge after accept.
            tx_shift = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               load_mode_d = 1'b0;
               state_d     = IDLE;
            end
         end

         READ: begin
            // The memory registers its output, so the first useful bit
            // arrives one edge after OUTPUT_MODE rises.
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q != '0) begin
               cap_shift = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
               output_mode_d = 1'b0;
            end
            if (cnt_q == CNT_FULL) begin
               rd_data_d  = {cap_q, SERIAL_OUT};
               rd_valid_d = 1'b1;
               state_d    = IDLE;
            end
         end

`ifdef GRID_LINK_STEP_EN
         STEP: begin
            // RUN_MODE was raised on entry; one cycle is a full generation.
            state_d = IDLE;
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase

      wr_ready_d = (state_d == IDLE);
   end

   // State, counter and output registers; reset drops the mode pins and
   // discards any capture in progress.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         WR_READY    <= 1'b0;
         LOAD_MODE   <= 1'b0;
         OUTPUT_MODE <= 1'b0;
         RD_VALID    <= 1'b0;
         RD_DATA     <= '0;
`ifdef GRID_LINK_STEP_EN
         RUN_MODE    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         WR_READY    <= wr_ready_d;
         LOAD_MODE   <= load_mode_d;
         OUTPUT_MODE <= output_mode_d;
         RD_VALID    <= rd_valid_d;
         RD_DATA     <= rd_data_d;
`ifdef GRID_LINK_STEP_EN
         RUN_MODE    <= run_mode_d;
`endif
      end
   end

   // By the final load edge every payload bit except the one on the line has
   // left the transmit shifter.
   tx_drained_a : assert property (@(posedge CLK) disable iff (!RESET_N)
      (state_q == LOAD && cnt_q == CNT_LAST) |-> (tx_q[DATA_SIZE-2:0] == '0));

endmodule : grid_serial_link

// File: tb/tb_grid_serial_link.sv
// Bench for grid_serial_link paired with a behavioural system memory model.
// The model shifts left inserting SERIAL_IN in load mode, rotates and drives
// a registered MSB in output mode, and takes the compute grid value in run mode.
module tb_grid_serial_link;

   localparam int N = 5;
   localparam logic [N-1:0] GRID_NEXT = 5'b00110;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_valid = 1'b0;
   logic [N-1:0] wr_data = '0;
   logic         wr_ready;
   logic         rd_req = 1'b0;
   logic         rd_valid;
   logic [N-1:0] rd_data;
   logic         serial_in;
   logic         load_mode;
   logic         output_mode;
   logic         serial_out;
   logic         run_mode;
`ifdef GRID_LINK_STEP_EN
   logic         step_req = 1'b0;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int valid_pulses = 0;
   int overlaps = 0;

   logic [N-1:0] mem = '0;
   logic         mem_so = 1'b0;

   always #5 clk = ~clk;

   grid_serial_link #(
      .DATA_SIZE   (N)
   ) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .WR_VALID    (wr_valid),
      .WR_DATA     (wr_data),
      .WR_READY    (wr_ready),
      .RD_REQ      (rd_req),
      .RD_VALID    (rd_valid),
      .RD_DATA     (rd_data),
      .SERIAL_IN   (serial_in),
      .LOAD_MODE   (load_mode),
      .OUTPUT_MODE (output_mode),
      .SERIAL_OUT  (serial_out)
`ifdef GRID_LINK_STEP_EN
      ,
      .STEP_REQ    (step_req),
      .RUN_MODE    (run_mode)
`endif
   );

`ifndef GRID_LINK_STEP_EN
   assign run_mode = 1'b0;
`endif

   assign serial_out = mem_so;

   // System memory model (has its own reset; not cleared by RESET_N).
   always @(posedge clk) begin
      if (load_mode) begin
         mem <= {mem[N-2:0], serial_in};
      end else if (output_mode) begin
         mem_so <= mem[N-1];
         mem    <= {mem[N-2:0], mem[N-1]};
      end else if (run_mode) begin
         mem <= GRID_NEXT;
      end
   end

   // Mid-cycle monitor: RD_VALID high cycles and mode-pin exclusivity.
   always @(negedge clk) begin
      if (rd_valid) valid_pulses++;
      if (int'(load_mode) + int'(output_mode) + int'(run_mode) > 1) overlaps++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load one word; expects WR_READY high on entry.
   task automatic do_write(input logic [N-1:0] data, input string tag);
      wr_valid = 1'b1;
      wr_data  = data;
      tick();
      wr_valid = 1'b0;
      wr_data  = ~data;
      for (int k = 0; k < N; k++) begin
         check({tag, " load_mode"}, 32'(load_mode), 32'(1));
         check({tag, " serial_in"}, 32'(serial_in), 32'(data[N-1-k]));
         check({tag, " wr_ready busy"}, 32'(wr_ready), 32'(0));
         tick();
      end
      check({tag, " load_mode end"}, 32'(load_mode), 32'(0));
      check({tag, " serial_in end"}, 32'(serial_in), 32'(0));
      check({tag, " wr_ready end"}, 32'(wr_ready), 32'(1));
      check({tag, " mem"}, 32'(mem), 32'(data));
   endtask

   // Read back one word with cycle-exact checks.
   task automatic do_read(input logic [N-1:0] exp, input string tag);
      int pulses_before;
      pulses_before = valid_pulses;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      for (int k = 0; k < N; k++) begin
         check({tag, " output_mode"}, 32'(output_mode), 32'(1));
         check({tag, " rd_valid early"}, 32'(rd_valid), 32'(0));
         tick();
      end
      check({tag, " output_mode end"}, 32'(output_mode), 32'(0));
      check({tag, " rd_valid e5"}, 32'(rd_valid), 32'(0));
      tick();
      check({tag, " rd_valid e6"}, 32'(rd_valid), 32'(1));
      check({tag, " rd_data"}, 32'(rd_data), 32'(exp));
      check({tag, " wr_ready"}, 32'(wr_ready), 32'(1));
      tick();
      check({tag, " rd_valid drop"}, 32'(rd_valid), 32'(0));
      check({tag, " rd_data hold"}, 32'(rd_data), 32'(exp));
      check({tag, " one pulse"}, 32'(valid_pulses - pulses_before), 32'(1));
      check({tag, " mem unchanged"}, 32'(mem), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  cyc;
      bit  seen;
      int  pulses_before;

      // Reset held low.
      #23;
      check("rst wr_ready", 32'(wr_ready), 32'(0));
      check("rst load_mode", 32'(load_mode), 32'(0));
      check("rst output_mode", 32'(output_mode), 32'(0));
      check("rst serial_in", 32'(serial_in), 32'(0));
      check("rst rd_valid", 32'(rd_valid), 32'(0));
      check("rst rd_data", 32'(rd_data), 32'(0));
      rst_n = 1'b1;
      tick();
      check("post rst wr_ready", 32'(wr_ready), 32'(1));
      check("post rst load_mode", 32'(load_mode), 32'(0));
      check("post rst output_mode", 32'(output_mode), 32'(0));
      check("post rst run_mode", 32'(run_mode), 32'(0));

      // Plain loads and a readback.
      do_write(5'b01001, "wr1");
      do_write(5'b01101, "wr2");
      do_read(5'b01101, "rd1");

      // Write and read requested together: load wins, read follows.
      wr_valid = 1'b1;
      wr_data  = 5'b11011;
      rd_req   = 1'b1;
      tick();
      wr_valid = 1'b0;
      check("coinc load first", 32'(load_mode), 32'(1));
      check("coinc no output", 32'(output_mode), 32'(0));
      cyc  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 30 && !seen; i++) begin
         tick();
         if (output_mode) rd_req = 1'b0;
         if (rd_valid) begin
            seen = 1'b1;
            cyc  = i;
         end
      end
      rd_req = 1'b0;
      check("coinc rd_valid seen", 32'(seen), 32'(1));
      check("coinc latency", 32'(cyc), 32'(12));
      check("coinc rd_data", 32'(rd_data), 32'(5'b11011));
      tick();

      // Reset during the third cycle of a READ.
      pulses_before = valid_pulses;
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      tick();
      check("abort output_mode before", 32'(output_mode), 32'(1));
      rst_n = 1'b0;
      #1;
      check("abort output_mode", 32'(output_mode), 32'(0));
      check("abort rd_data", 32'(rd_data), 32'(0));
      check("abort rd_valid", 32'(rd_valid), 32'(0));
      check("abort wr_ready", 32'(wr_ready), 32'(0));
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("abort no pulse", 32'(valid_pulses - pulses_before), 32'(0));
      check("abort rd_data after", 32'(rd_data), 32'(0));
      check("abort wr_ready after", 32'(wr_ready), 32'(1));

`ifdef GRID_LINK_STEP_EN
      // Single generation step.
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      check("step run_mode", 32'(run_mode), 32'(1));
      check("step wr_ready busy", 32'(wr_ready), 32'(0));
      tick();
      check("step run_mode drop", 32'(run_mode), 32'(0));
      check("step wr_ready", 32'(wr_ready), 32'(1));
      check("step mem", 32'(mem), 32'(GRID_NEXT));
`endif

      check("mode pins exclusive", 32'(overlaps), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule : tb_grid_serial_link

// File: doc/grid_serial_link.md
# grid_serial_link

Host-side controller for the serial port of the system memory block. It accepts a parallel grid word from the host and shifts it into the system memory by driving `SERIAL_IN` and `LOAD_MODE`. It also captures a parallel grid word by driving `OUTPUT_MODE` and sampling `SERIAL_OUT`. It is the sole driver of the system memory mode pins and never asserts more than one of them at a time.

## Interface
- `DATA_SIZE`, default 5: grid word width in bits, ≥ 2.
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `WR_VALID` in 1: host offers a word for loading.
- `WR_DATA` in `DATA_SIZE`: word to load.
- `WR_READY` out 1: high when state is IDLE; a transfer occurs on an edge where `WR_VALID` and `WR_READY` are both high.
- `RD_REQ` in 1: host requests a readback; accepted on an edge in IDLE.
- `RD_VALID` out 1: one-cycle pulse; `RD_DATA` is valid while it is high.
- `RD_DATA` out `DATA_SIZE`: captured word, held until the next capture completes.
- `SERIAL_IN` out 1: serial data to the system memory.
- `LOAD_MODE` out 1: system memory serial-load enable.
- `OUTPUT_MODE` out 1: system memory serial-output enable.
- `SERIAL_OUT` in 1: serial data from the system memory.
- `STEP_REQ` in 1: only present with `GRID_LINK_STEP_EN`.
- `RUN_MODE` out 1: only present with `GRID_LINK_STEP_EN`.

## Operation
- All outputs are registered. Reset value is 0 for every output, including `RD_DATA`. While `RESET_N` is low, `WR_READY` is 0.
- States:
  - IDLE
  - LOAD
  - READ
  - STEP (only with `GRID_LINK_STEP_EN`)
- The bit counter `cnt` is `$clog2(DATA_SIZE+2)` bits wide. It counts up from 0 and saturation is never reached.
- IDLE priority when requests coincide: write first, then step, then read. A request that is not taken stays pending only if the host holds it high.
- Bit order is MSB first in both directions. The memory shifts left and inserts the new bit at the LSB. It emits its MSB first.
- IDLE→LOAD on write accept:
  - Latch `WR_DATA`.
  - Set `LOAD_MODE=1` and `SERIAL_IN=WR_DATA[DATA_SIZE-1]`.
  - Set `cnt=0`.
- LOAD, each edge:
  - Present the next lower bit on `SERIAL_IN`.
  - On the edge where `cnt==DATA_SIZE-1`, clear `LOAD_MODE` and `SERIAL_IN` and return to IDLE.
- IDLE→READ on `RD_REQ`: set `OUTPUT_MODE=1` and `cnt=0`.
- READ, each edge:
  - `cnt` increments.
  - When `cnt≥1`, shift `SERIAL_OUT` into the LSB of the capture register.
  - `OUTPUT_MODE` clears on the edge where `cnt==DATA_SIZE-1`.
  - On the edge where `cnt==DATA_SIZE`, the final bit is captured, `RD_DATA` is updated, `RD_VALID` pulses, and the state returns to IDLE.
- `WR_DATA` changes after accept have no effect. `RD_REQ` and `WR_VALID` are ignored outside IDLE.
- Reset mid-operation:
  - Mode pins drop asynchronously.
  - Any partial capture is discarded and `RD_DATA` is cleared.
  - The system memory contents are not this block's concern; it has its own reset.

## Timing
Let `e0` be the accept edge.
- **Load**
  - `LOAD_MODE` is high from `e0` to `eN`, where N=`DATA_SIZE`.
  - The memory receives bit N-1-k at edge `e(k+1)`.
  - `WR_READY` returns high after `eN`, so the next accept is possible at `e(N+1)`.
  - Total: N cycles busy.
- **Read**
  - `OUTPUT_MODE` is high from `e0` to `eN`. The memory shifts out on edges `e1..eN`.
  - The capture register samples bit N-k at edge `e(k+1)`, for k=1..N.
  - `RD_VALID` is high for the cycle following `e(N+1)`.
  - Total: N+1 cycles busy.
- **Step**: `RUN_MODE` is high for exactly one cycle (`e0` to `e1`), then the state returns to IDLE.

## Configuration
- `GRID_LINK_STEP_EN` defined:
  - Adds `STEP_REQ`, `RUN_MODE` and the STEP state.
  - A step request in IDLE pulses `RUN_MODE` for one cycle, which commits the next generation from the compute grid.
- Undefined:
  - The ports and the state are absent.
  - The system memory `RUN_MODE` pin is tied low at the top level.

## Structure
- Package `grid_link_pkg`:
  - State enum typedef `link_state_t`, with STEP included under the macro.
  - Function `cnt_width(DATA_SIZE)`.
- Sub-module `link_shift_reg`:
  - Parameterized width.
  - Parallel load, shift-left with serial input at the LSB, MSB serial output.
  - Two instances: a transmit shifter and a capture shifter.
- The FSM and counter live in the top module.

## Test plan
The bench pairs the block with the system memory block and uses `DATA_SIZE`=5.
- Reset check: hold `RESET_N` low, then release → all outputs 0 and `WR_READY=1`.
- Write `5'b01001` → `LOAD_MODE` high for 5 cycles and `SERIAL_IN` sequence 0,1,0,0,1 → memory output is `5'b01001`, `WR_READY` is low for 5 cycles.
- After loading `5'b01101`, assert `RD_REQ` → `OUTPUT_MODE` high for 5 cycles → `RD_VALID` pulses once 6 cycles after accept with `RD_DATA=5'b01101` → memory contents unchanged.
- Assert `WR_VALID` and `RD_REQ` on the same edge with `WR_DATA=5'b11011` → load first, `RD_DATA` returns `5'b11011` → no two mode pins are ever high together.
- Pull `RESET_N` low at cycle 3 of a READ → `OUTPUT_MODE=0` immediately, `RD_VALID` never pulses, `RD_DATA=0`.
- With `GRID_LINK_STEP_EN` defined, pulse `STEP_REQ` → `RUN_MODE` high for exactly 1 cycle → the memory holds the compute grid value `5'b00110`.
